// File: rtl/rx_os_framer_if.sv
// Symbol/OS-framing bundle between a lane receiver and the ordered-set framer.
interface rx_os_framer_if #(
   parameter int SYMBOL_WIDTH     = 8,
   parameter int SYMBOL_NUM_WIDTH = 4
);
   logic [SYMBOL_WIDTH-1:0]     i_symbol;
   logic                        i_symbol_valid;
   logic                        i_is_k;
   logic                        gen;
   logic                        i_block_start;
   logic                        Block_Type;
   logic [SYMBOL_WIDTH-1:0]     o_symbol;
   logic [SYMBOL_NUM_WIDTH-1:0] o_symbol_count;
   logic                        o_valid_lower_gen;
   logic                        o_valid_gen3;
   logic                        o_os_done;
   logic                        o_err;
   logic [7:0]                  o_err_count;

   modport master (
      output i_symbol, i_symbol_valid, i_is_k, gen, i_block_start, Block_Type,
      input  o_symbol, o_symbol_count, o_valid_lower_gen, o_valid_gen3,
             o_os_done, o_err, o_err_count
   );
   modport slave (
      input  i_symbol, i_symbol_valid, i_is_k, gen, i_block_start, Block_Type,
      output o_symbol, o_symbol_count, o_valid_lower_gen, o_valid_gen3,
             o_os_done, o_err, o_err_count
   );
endinterface

// File: rtl/rx_os_framer.sv
// Per-lane ordered-set framer for Gen1/2 (8b/10b) and Gen3+ (128b/130b) symbol streams.
// Define RX_OS_FRAMER_ERRCNT_EN to build the saturating framing-error counter.
module rx_os_framer #(
   parameter int SYMBOL_WIDTH     = 8,
   parameter int SYMBOL_NUM_WIDTH = 4
) (
   input logic              clk,
   input logic              rst,
   rx_os_framer_if.slave    bus
);
   localparam logic [SYMBOL_WIDTH-1:0]     K_COM  = SYMBOL_WIDTH'(8'hBC);
   localparam logic [SYMBOL_WIDTH-1:0]     K_SKP  = SYMBOL_WIDTH'(8'h1C);
   localparam logic [SYMBOL_WIDTH-1:0]     K_FTS  = SYMBOL_WIDTH'(8'h3C);
   localparam logic [SYMBOL_WIDTH-1:0]     K_IDL  = SYMBOL_WIDTH'(8'h7C);
   localparam logic [SYMBOL_WIDTH-1:0]     G3_SKP = SYMBOL_WIDTH'(8'hAA);
   localparam logic [SYMBOL_NUM_WIDTH-1:0] LAST_S = SYMBOL_NUM_WIDTH'(3);
   localparam logic [SYMBOL_NUM_WIDTH-1:0] LAST_L = SYMBOL_NUM_WIDTH'(15);

   typedef enum logic [1:0] {IDLE, SHORT_OS, LONG_OS, G3_OS} state_t;

   state_t                      r_state, w_nstate;
   logic [SYMBOL_NUM_WIDTH-1:0] r_cnt, w_ncnt;     // index the next valid symbol receives
   logic                        r_skp, w_nskp;
   logic                        r_gen;
   logic [SYMBOL_WIDTH-1:0]     r_symbol;
   logic [SYMBOL_NUM_WIDTH-1:0] r_ocnt, w_ocnt;
   logic                        r_vlg, w_vlg, r_vg3, w_vg3, r_done, w_done, r_err, w_err;
   logic                        w_com, w_short_k;
   logic [SYMBOL_NUM_WIDTH-1:0] w_last;

   always_comb begin
      w_nstate  = r_state;
      w_ncnt    = r_cnt;
      w_nskp    = r_skp;
      w_ocnt    = r_ocnt;
      w_vlg     = 1'b0;
      w_vg3     = 1'b0;
      w_done    = 1'b0;
      w_err     = 1'b0;
      w_com     = bus.i_is_k && (bus.i_symbol == K_COM);
      w_short_k = bus.i_is_k && ((bus.i_symbol == K_SKP) || (bus.i_symbol == K_FTS) ||
                                 (bus.i_symbol == K_IDL));
      w_last    = (r_state == SHORT_OS) ? LAST_S : LAST_L;
      if (bus.gen != r_gen) begin
         // rate change: drop whatever was in flight, emit nothing this cycle
         w_nstate = IDLE;
         w_ncnt   = '0;
         w_nskp   = 1'b0;
      end else if (bus.i_symbol_valid) begin
         case (r_state)
            IDLE: begin
               if (!bus.gen) begin
                  if (w_com) begin
                     w_ocnt   = '0;
                     w_vlg    = 1'b1;
                     w_nstate = LONG_OS;
                     w_ncnt   = SYMBOL_NUM_WIDTH'(1);
                  end else begin
                     w_err = 1'b1;
                  end
               end else if (bus.i_block_start && bus.Block_Type) begin
                  w_ocnt   = '0;
                  w_vg3    = (bus.i_symbol != G3_SKP);
                  w_nskp   = (bus.i_symbol == G3_SKP);
                  w_nstate = G3_OS;
                  w_ncnt   = SYMBOL_NUM_WIDTH'(1);
               end
            end
            SHORT_OS, LONG_OS: begin
               w_vlg = 1'b1;
               if (w_com) begin
                  w_err    = 1'b1;
                  w_ocnt   = '0;
                  w_nstate = LONG_OS;
                  w_ncnt   = SYMBOL_NUM_WIDTH'(1);
               end else begin
                  w_ocnt = r_cnt;
                  if (r_cnt == w_last) begin
                     w_done   = 1'b1;
                     w_nstate = IDLE;
                     w_ncnt   = '0;
                  end else begin
                     w_ncnt = r_cnt + 1'b1;
                     if ((r_state == LONG_OS) && (r_cnt == SYMBOL_NUM_WIDTH'(1)) && w_short_k)
                        w_nstate = SHORT_OS;
                  end
               end
            end
            G3_OS: begin
               if (bus.i_block_start) begin
                  w_err = 1'b1;
                  if (bus.Block_Type) begin
                     w_ocnt   = '0;
                     w_vg3    = (bus.i_symbol != G3_SKP);
                     w_nskp   = (bus.i_symbol == G3_SKP);
                     w_ncnt   = SYMBOL_NUM_WIDTH'(1);
                  end else begin
                     w_nstate = IDLE;
                     w_ncnt   = '0;
                     w_nskp   = 1'b0;
                  end
               end else begin
                  w_ocnt = r_cnt;
                  w_vg3  = !r_skp;
                  if (r_cnt == LAST_L) begin
                     w_done   = 1'b1;
                     w_nstate = IDLE;
                     w_ncnt   = '0;
                     w_nskp   = 1'b0;
                  end else begin
                     w_ncnt = r_cnt + 1'b1;
                  end
               end
            end
            default: begin
               w_nstate = IDLE;
               w_ncnt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_skp    <= 1'b0;
         r_gen    <= bus.gen;
         r_symbol <= '0;
         r_ocnt   <= '0;
         r_vlg    <= 1'b0;
         r_vg3    <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_nstate;
         r_cnt    <= w_ncnt;
         r_skp    <= w_nskp;
         r_gen    <= bus.gen;
         r_symbol <= bus.i_symbol;
         r_ocnt   <= w_ocnt;
         r_vlg    <= w_vlg;
         r_vg3    <= w_vg3;
         r_done   <= w_done;
         r_err    <= w_err;
      end
   end

`ifdef RX_OS_FRAMER_ERRCNT_EN
   logic [7:0] r_err_cnt;
   always_ff @(posedge clk) begin
      if (rst)
         r_err_cnt <= '0;
      else if (w_err && (r_err_cnt != 8'hFF))
         r_err_cnt <= r_err_cnt + 8'd1;
   end
   assign bus.o_err_count = r_err_cnt;
`else
   assign bus.o_err_count = '0;
`endif

   assign bus.o_symbol          = r_symbol;
   assign bus.o_symbol_count    = r_ocnt;
   assign bus.o_valid_lower_gen = r_vlg;
   assign bus.o_valid_gen3      = r_vg3;
   assign bus.o_os_done         = r_done;
   assign bus.o_err             = r_err;
endmodule
